dsm_cfg_loader: RTL

Serial configuration sequencer for the delta-sigma modulator's serial-to-parallel input register. Accepts a fractional word over a valid/ready handshake and shifts it out MSB-first on `sclk`/`sdata`, framed by `en`, at a programmable serial rate. Holds one pending word so the PLL control logic can queue the next frequency update while a frame is in flight. Sits between the loop-control logic and the DSM top-level serial pins.

---
 rtl/dsm_cfg_pkg.sv | 15 +
 rtl/dsm_cfg_tick.sv | 29 ++
 rtl/dsm_cfg_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dsm_cfg_pkg.sv
// rtl/dsm_cfg_pkg.sv - shared types and constants for the DSM configuration loader
package dsm_cfg_pkg;

  // Loader sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_TAIL = 2'd3
  } dsm_cfg_state_t;

  // Length of the DSM serial-to-parallel input register
  localparam int DSM_WORD_W = 9;

endpackage

// File: rtl/dsm_cfg_tick.sv
// rtl/dsm_cfg_tick.sv - sclk half-period divider producing a one-cycle tick
module dsm_cfg_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..HALF_DIV-1 and wrap; clr pins the phase at zero so a frame starts aligned
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dsm_cfg_loader.sv
// rtl/dsm_cfg_loader.sv - serial frame sequencer with one-word pending slot for the DSM input register
module dsm_cfg_loader
  import dsm_cfg_pkg::*;
#(
  parameter int WIDTH    = DSM_WORD_W,
  parameter int HALF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  dsm_cfg_state_t   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             pend_v_q, pend_v_d;
  logic             gap_q, gap_d;
  logic             accept;
  logic             start;
  logic [WIDTH-1:0] ld_word;
  logic [WIDTH-1:0] shifted;
  logic             tick;

  assign in_ready = ~pend_v_q;
  assign accept   = in_valid & ~pend_v_q;
  assign busy     = (state_q != ST_IDLE) | pend_v_q;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign en       = en_q;
  assign done     = done_q;

  // Divider runs only inside a frame; parking it in IDLE makes every frame start phase-aligned
  dsm_cfg_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .tick  (tick)
  );

  // State, shift buffer, pending slot and registered serial outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      pend_data_q <= '0;
      pend_v_q    <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      en_q        <= en_d;
      done_q      <= done_d;
      pend_data_q <= pend_data_d;
      pend_v_q    <= pend_v_d;
      gap_q       <= gap_d;
    end
  end

  // Next-state logic: frame sequencing, bit shifting and pending-slot management
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    en_d        = en_q;
    done_d      = 1'b0;
    pend_data_d = pend_data_q;
    pend_v_d    = pend_v_q;
    gap_d       = gap_q;
    start       = 1'b0;
    ld_word     = in_data;
    shifted     = shreg_q << 1;

    // Any accept outside IDLE (including the TAIL exit edge) parks the word in the slot
    if (state_q != ST_IDLE && accept) begin
      pend_data_d = in_data;
      pend_v_d    = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (pend_v_q) begin
          start    = 1'b1;
          ld_word  = pend_data_q;
          pend_v_d = 1'b0;
        end else if (accept) begin
          start = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = ST_TAIL;
          end else begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q - 1'b1;
            sdata_d   = shifted[WIDTH-1];
            state_d   = ST_LOW;
          end
        end
      end
      ST_TAIL: begin
        if (tick) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          gap_d   = pend_v_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame launch: MSB presented with sclk low so it is settled before the first rising edge
    if (start) begin
      shreg_d   = ld_word;
      bit_cnt_d = BCW'(WIDTH - 1);
      en_d      = 1'b1;
      sdata_d   = ld_word[WIDTH-1];
      sclk_d    = 1'b0;
      state_d   = ST_LOW;
    end
  end

endmodule
